// File: rtl/se_fc_engine.sv
// Fully-connected layer of the squeeze-and-excite path: buffers one activation
// vector, streams row-major weights and emits one rescaled, saturated result per neuron.
module se_fc_engine #(
  parameter int IN_CH   = 16,
  parameter int OUT_CH  = 4,
  parameter int BITSIZE = 14,
  parameter int ACC_W   = 32,
  parameter int FRAC    = 8,
  parameter int RELU    = 1,
  parameter int W_BASE  = 0,
  localparam int OW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic signed [BITSIZE-1:0] in_data,
  output logic                      w_en,
  output logic                      w_rd,
  output logic [14:0]               w_index,
  input  logic signed [BITSIZE-1:0] w_data,
  output logic                      out_valid,
  output logic [OW-1:0]             out_idx,
  output logic signed [BITSIZE-1:0] out_data,
  output logic                      busy,
  output logic                      done
);

  localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic [CW-1:0] LAST_I = CW'(IN_CH - 1);
  localparam logic [OW-1:0] LAST_O = OW'(OUT_CH - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (BITSIZE - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  logic [CW-1:0]              r_cnt;
  logic [CW-1:0]              r_i;
  logic [OW-1:0]              r_o;
  logic                       r_tag_v;
  logic                       r_tag_last;
  logic [CW-1:0]              r_tag_i;
  logic [OW-1:0]              r_tag_o;
  logic signed [BITSIZE-1:0]  r_act [IN_CH];
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_w_en;
  logic [14:0]                r_w_index;
  logic                       r_out_valid;
  logic [OW-1:0]              r_out_idx;
  logic signed [BITSIZE-1:0]  r_out_data;
  logic                       r_busy;
  logic                       r_done;

  logic signed [2*BITSIZE-1:0] w_prod;
  logic signed [ACC_W-1:0]     w_prod_ext;
  logic signed [ACC_W-1:0]     w_sum;
  logic signed [ACC_W-1:0]     w_shift;
  logic signed [BITSIZE-1:0]   w_sat;
  logic signed [BITSIZE-1:0]   w_res;

  assign w_prod     = w_data * r_act[r_tag_i];
  assign w_prod_ext = {{(ACC_W - 2*BITSIZE){w_prod[2*BITSIZE-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_shift    = w_sum >>> FRAC;

  always_comb begin
    if (w_shift > SAT_MAX)
      w_sat = {1'b0, {(BITSIZE-1){1'b1}}};
    else if (w_shift < SAT_MIN)
      w_sat = {1'b1, {(BITSIZE-1){1'b0}}};
    else
      w_sat = w_shift[BITSIZE-1:0];
    w_res = ((RELU != 0) && w_sat[BITSIZE-1]) ? '0 : w_sat;
  end

  // Activation buffer carries no reset: it is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && in_valid)
      r_act[r_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_i         <= '0;
      r_o         <= '0;
      r_tag_v     <= 1'b0;
      r_tag_last  <= 1'b0;
      r_tag_i     <= '0;
      r_tag_o     <= '0;
      r_acc       <= '0;
      r_w_en      <= 1'b0;
      r_w_index   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_LOAD;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
        end
        S_LOAD: if (in_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_I) begin
            r_state   <= S_RUN;
            r_w_en    <= 1'b1;
            r_w_index <= 15'(W_BASE);
            r_i       <= '0;
            r_o       <= '0;
          end
        end
        S_RUN: begin
          r_w_index <= r_w_index + 15'd1;
          if (r_i == LAST_I) begin
            r_i <= '0;
            if (r_o == LAST_O) begin
              r_state <= S_DRAIN;
              r_w_en  <= 1'b0;
            end else begin
              r_o <= r_o + 1'b1;
            end
          end else begin
            r_i <= r_i + 1'b1;
          end
        end
        // Leave once the final neuron's result is on the output register.
        S_DRAIN: if (r_out_valid && r_out_idx == LAST_O) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase

      r_tag_v    <= (r_state == S_RUN);
      r_tag_i    <= r_i;
      r_tag_o    <= r_o;
      r_tag_last <= (r_i == LAST_I);

      r_out_valid <= 1'b0;
      if (r_tag_v) begin
        if (r_tag_last) begin
          r_out_data  <= w_res;
          r_out_idx   <= r_tag_o;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign w_en      = r_w_en;
  assign w_rd      = r_w_en;
  assign w_index   = r_w_index;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_se_fc_engine.sv
// Bench for se_fc_engine: two instances (ReLU on / off) share stimulus and a
// weight memory; results are checked against hand tables and an arithmetic model.
module tb_se_fc_engine;

  localparam int IN_CH = 4;
  localparam int OUT_CH = 2;
  localparam int N = IN_CH * OUT_CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic signed [13:0] in_data = '0;
  logic signed [13:0] w_data = '0;

  logic               r_w_en, r_w_rd, r_out_valid, r_busy, r_done;
  logic [14:0]        r_w_index;
  logic [0:0]         r_out_idx;
  logic signed [13:0] r_out_data;
  logic               l_w_en, l_w_rd, l_out_valid, l_busy, l_done;
  logic [14:0]        l_w_index;
  logic [0:0]         l_out_idx;
  logic signed [13:0] l_out_data;

  se_fc_engine #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .BITSIZE(14), .ACC_W(32),
                 .FRAC(8), .RELU(1), .W_BASE(0)) u_dut_relu (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .w_en(r_w_en), .w_rd(r_w_rd), .w_index(r_w_index), .w_data(w_data),
    .out_valid(r_out_valid), .out_idx(r_out_idx), .out_data(r_out_data),
    .busy(r_busy), .done(r_done));

  se_fc_engine #(.IN_CH(IN_CH), .OUT_CH(OUT_CH), .BITSIZE(14), .ACC_W(32),
                 .FRAC(8), .RELU(0), .W_BASE(0)) u_dut_lin (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .w_en(l_w_en), .w_rd(l_w_rd), .w_index(l_w_index), .w_data(w_data),
    .out_valid(l_out_valid), .out_idx(l_out_idx), .out_data(l_out_data),
    .busy(l_busy), .done(l_done));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tb_act [IN_CH];
  int tb_wt [N];
  int exp_r [OUT_CH];
  int exp_l [OUT_CH];

  // Weight memory: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) begin
    if (r_w_en && r_w_index < 15'(N))
      w_data <= 14'(tb_wt[r_w_index]);
    else
      w_data <= 14'($urandom);
  end

  typedef struct packed {
    logic [3:0][31:0] act;
    logic [7:0][31:0] wt;
    logic [31:0]      stall;
    logic [1:0][31:0] e_r;
    logic [1:0][31:0] e_l;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_out(input int o, input bit relu);
    longint s = 0;
    for (int i = 0; i < IN_CH; i++) s += longint'(tb_act[i]) * longint'(tb_wt[o*IN_CH + i]);
    s = s >>> 8;
    if (s > 8191) s = 8191;
    if (s < -8192) s = -8192;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns number of LOAD cycles; stall mode 0=none, 1=fixed pattern, 2=random.
  task automatic do_load(input int stall, output int lcyc);
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    int words = 0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    lcyc = 0;
    while (words < IN_CH && lcyc < 64) begin
      if (stall == 0) in_valid = 1'b1;
      else if (stall == 1) in_valid = (lcyc < 7) ? pat[lcyc][0] : 1'b1;
      else in_valid = 1'($urandom_range(0, 1));
      in_data = in_valid ? 14'(tb_act[words]) : 14'($urandom);
      tick();
      lcyc++;
      if (in_valid) words++;
    end
    in_valid = 1'b0;
    if (words < IN_CH) chk("load_timeout", words, IN_CH);
  endtask

  task automatic do_run(input int id, input int stall, input bit poke);
    int lcyc;
    int got0 = 0;
    int got1 = 0;
    do_load(stall, lcyc);
    if (stall == 1) chk("load_cycles", lcyc, 7);
    for (int t = 0; t <= N + 3; t++) begin
      bit ov_e = (t == IN_CH + 1) || (t == 2*IN_CH + 1);
      chk("w_en", r_w_en, t < N);
      chk("w_rd", r_w_rd, t < N);
      chk("lin_w_en", l_w_en, t < N);
      if (t < N) begin
        chk("w_index", r_w_index, t);
        chk("lin_w_index", l_w_index, t);
      end
      chk("out_valid", r_out_valid, ov_e);
      chk("lin_out_valid", l_out_valid, ov_e);
      if (ov_e) begin
        int o = (t == IN_CH + 1) ? 0 : 1;
        chk("out_idx", r_out_idx, o);
        chk("out_data", r_out_data, exp_r[o]);
        chk("lin_out_data", l_out_data, exp_l[o]);
        if (o == 0) got0 = int'(r_out_data); else got1 = int'(r_out_data);
      end
      chk("done", r_done, t == N + 2);
      chk("lin_done", l_done, t == N + 2);
      chk("busy", r_busy, t <= N + 2);
      if (poke && t == 2) begin
        start = 1'b1;
        in_valid = 1'b1;
        in_data = 14'($urandom);
      end
      tick();
      start = 1'b0;
      in_valid = 1'b0;
    end
    $display("run %0d stall=%0d load=%0d relu_out=%0d,%0d lin_exp=%0d,%0d",
             id, stall, lcyc, got0, got1, exp_l[0], exp_l[1]);
  endtask

  task automatic apply_vec(input vec_t v);
    for (int k = 0; k < IN_CH; k++) tb_act[k] = int'($signed(v.act[k]));
    for (int k = 0; k < N; k++) tb_wt[k] = int'($signed(v.wt[k]));
    for (int k = 0; k < OUT_CH; k++) begin
      exp_r[k] = int'($signed(v.e_r[k]));
      exp_l[k] = int'($signed(v.e_l[k]));
    end
  endtask

  vec_t vt [5];

  initial begin
    vt[0] = '{act: {4{32'sd256}},
              wt: {{4{-32'sd256}}, 32'sd0, -32'sd256, 32'sd512, 32'sd256},
              stall: 0, e_r: {32'sd0, 32'sd512}, e_l: {-32'sd1024, 32'sd512}};
    vt[1] = vt[0];
    vt[1].stall = 1;
    vt[2] = '{act: {4{32'sd8191}}, wt: {8{32'sd8191}},
              stall: 0, e_r: {32'sd8191, 32'sd8191}, e_l: {32'sd8191, 32'sd8191}};
    vt[3] = '{act: {4{32'sd8191}}, wt: {8{-32'sd8192}},
              stall: 0, e_r: {32'sd0, 32'sd0}, e_l: {-32'sd8192, -32'sd8192}};
    vt[4] = '{act: {4{32'sd8191}}, wt: {{4{-32'sd8192}}, {4{32'sd8191}}},
              stall: 2, e_r: {32'sd0, 32'sd8191}, e_l: {-32'sd8192, 32'sd8191}};

    // Reset with random inputs toggling
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      start = 1'($urandom);
      in_valid = 1'($urandom);
      in_data = 14'($urandom);
      tick();
    end
    chk("rst_w_en", r_w_en, 0);
    chk("rst_w_rd", r_w_rd, 0);
    chk("rst_w_index", r_w_index, 0);
    chk("rst_out_valid", r_out_valid, 0);
    chk("rst_out_idx", r_out_idx, 0);
    chk("rst_out_data", r_out_data, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_done", r_done, 0);
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      apply_vec(vt[v]);
      do_run(v, int'(vt[v].stall), 1'b0);
    end

    // Abort mid-RUN at T0+3
    apply_vec(vt[0]);
    begin
      int lcyc;
      do_load(0, lcyc);
      for (int t = 0; t < 3; t++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_w_en", r_w_en, 0);
      chk("abort_busy", r_busy, 0);
      chk("abort_out_valid", r_out_valid, 0);
      chk("abort_lin_busy", l_busy, 0);
      for (int t = 0; t < 12; t++) begin
        chk("abort_quiet_ov", r_out_valid | l_out_valid, 0);
        chk("abort_quiet_done", r_done | l_done, 0);
        tick();
      end
      $display("run abort: reset at T0+3");
    end
    do_run(10, 0, 1'b1);
    do_run(11, 0, 1'b0);

    // Randomised vectors against the arithmetic model
    for (int r = 0; r < 10; r++) begin
      int mag = (r < 5) ? 8191 : 300;
      for (int k = 0; k < IN_CH; k++) tb_act[k] = int'($urandom_range(0, 2*mag)) - mag;
      for (int k = 0; k < N; k++) tb_wt[k] = int'($urandom_range(0, 2*mag)) - mag;
      for (int o = 0; o < OUT_CH; o++) begin
        exp_r[o] = ref_out(o, 1'b1);
        exp_l[o] = ref_out(o, 1'b0);
      end
      do_run(20 + r, 2, r[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/se_fc_engine.md
# se_fc_engine

Fully-connected compute engine for the squeeze-and-excite path. It captures one squeezed activation vector of IN_CH signed values and drives read requests into the FC weight memory segment. It multiplies each returned weight with the matching activation and accumulates one dot product per output neuron. Each result is rescaled, saturated and optionally ReLU'd, then emitted as a 14-bit stream of OUT_CH values to the next SE stage (second FC layer or hard-sigmoid).

## Interface

Parameters:
- IN_CH, 16: activations per vector, which is also the dot-product length.
- OUT_CH, 4: output neurons per run.
- BITSIZE, 14: width of activations, weights and outputs (signed).
- ACC_W, 32: accumulator width (signed).
- FRAC, 8: arithmetic right shift applied to the final accumulator.
- RELU, 1: 1 clamps negative outputs to 0; 0 passes them through.
- W_BASE, 0: first weight-memory index used by this layer.

Ports:
- clk  in  1  clock. Single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run. Honoured only in IDLE.
- in_valid  in  1  activation word valid. Sampled only in LOAD.
- in_data  in  BITSIZE  signed activation.
- w_en  out  1  weight-memory enable.
- w_rd  out  1  weight-memory read strobe. Always equal to w_en.
- w_index  out  15  weight-memory address.
- w_data  in  BITSIZE  signed weight. Valid exactly one cycle after a read is issued.
- out_valid  out  1  one-cycle pulse per output neuron.
- out_idx  out  clog2(OUT_CH)  neuron number of out_data.
- out_data  out  BITSIZE  signed result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last output.

## Operation

- The engine only reads weight memory; it never writes it.
- Weight layout is row-major: weight (o,i) is at index W_BASE + o*IN_CH + i.
- Activation buffer: IN_CH x BITSIZE registers, loaded in index order.

FSM states and transitions:
- IDLE. start → LOAD, and the load counter is cleared.
- LOAD. Each cycle with in_valid=1 writes in_data to act[cnt] and increments cnt. Cycles with in_valid=0 stall. The cycle that accepts word IN_CH-1 moves the FSM → RUN.
- RUN. One read is issued per cycle, with no bubbles:
  - w_en=w_rd=1.
  - (o,i) steps i = 0..IN_CH-1, then o+1.
  - A 1-cycle delayed tag (valid, i, last, o) travels alongside each read.
  - After issuing (OUT_CH-1, IN_CH-1) → DRAIN.
- DRAIN. No reads are issued. The cycle that registers the last output moves the FSM → DONE.
- DONE. done=1 for one cycle, then → IDLE.

Datapath:
- In the cycle a tagged read returns, the product is w_data * act[i_tag], a signed 2*BITSIZE value sign-extended to ACC_W.
- If the tag is not last: acc += product.
- If the tag is last:
  - sum = acc + product.
  - r = sum >>> FRAC, arithmetic shift.
  - Saturate r to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - If RELU=1 and r<0, r=0.
  - Register r into out_data, set out_valid=1 and out_idx=o_tag.
  - Clear acc to 0 in the same cycle, so the next neuron starts clean.
- w_data is ignored in any cycle without a valid tag. The memory output is not reset.

## Timing

- Reset values:
  - State IDLE.
  - busy, done, out_valid, w_en and w_rd are 0.
  - w_index, out_data, out_idx and acc are 0.
  - Load counter and tags are cleared.
- Let T0 be the first RUN cycle.
  - The read for (o,i) is issued at T0 + o*IN_CH + i.
  - Its data is consumed at that cycle +1.
  - out_valid for neuron o is high at T0 + (o+1)*IN_CH + 1.
  - done is high at T0 + OUT_CH*IN_CH + 2.
  - busy falls on the following cycle.
- RUN latency from start = LOAD cycles + OUT_CH*IN_CH + 3.
- Simultaneous events and boundaries:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored, and no state changes.
  - Any rst cycle, including one mid-LOAD or mid-RUN, returns the block to IDLE on the next edge with reset values. An in-flight tag is discarded, and no out_valid or done is produced for the aborted run.
  - IN_CH=1 is legal: every tag is last, and one output is produced per cycle.

## Test plan

Test configuration: IN_CH=4, OUT_CH=2, FRAC=8, RELU=1, W_BASE=0.

- **Reset:** assert rst for 2 cycles with random inputs → all outputs 0 and busy=0.
- **Basic run:**
  - Stimulus: activations 256,256,256,256; weights 256,512,-256,0 (neuron 0) and -256×4 (neuron 1).
  - w_index must read 0..7, one per cycle from T0.
  - out_data=512 with out_idx=0 at T0+5.
  - out_data=0 (ReLU of -1024) at T0+9.
  - done at T0+10.
- **RELU=0:** same stimulus → neuron 1 out_data=-1024.
- **Saturation:**
  - All activations 8191 and all weights 8191 → out_data=8191 for both neurons.
  - All activations 8191 and all weights -8192 with RELU=0 → out_data=-8192.
- **LOAD stalls:** in_valid pattern 1,0,0,1,1,0,1 → LOAD lasts 7 cycles, and results are identical to the basic run.
- **Abort and restart:**
  - rst during the RUN cycle at T0+3 → next cycle w_en=0, busy=0, and no out_valid.
  - start pulsed in the same cycle as in_valid during RUN has no effect.
  - A fresh start after the abort reproduces the basic-run results.
